// File: rtl/cmd_dec_pkg.sv
// Shared definitions for the multi-channel command decoder.
// Holds the command word field positions and the reject-code encoding.
package cmd_dec_pkg;

  // Action flag bit positions inside the command word
  localparam int unsigned BIT_ON   = 0;
  localparam int unsigned BIT_OFF  = 1;
  localparam int unsigned BIT_INC  = 2;
  localparam int unsigned BIT_DEC  = 3;
  localparam int unsigned BIT_RX   = 4;
  localparam int unsigned BIT_TX   = 5;
  localparam int unsigned BIT_EXEC = 6;
  localparam int unsigned FLAGS_W  = 7;

  // Multi-bit field positions
  localparam int unsigned STEP_LSB = 8;
  localparam int unsigned CH_LSB   = 16;
  localparam int unsigned CH_W     = 8;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CONFLICT = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_OFF      = 2'd3
  } err_code_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, no read bypass.
// Ports: clk, rst_n (async active-low), push_i/pop_i requests (ignored when
// full/empty), wdata_i write word, rdata_o head word, full_o, empty_o.
module cmd_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_decoder_mc.sv
// Buffered multi-channel command decoder.
// Commands enter a FIFO over a valid/ready handshake, are popped into a
// decode stage, then checked and executed into registered outputs.
// Ports: clk, rst_n, in_valid/in_ready/received_data (command input),
// stall (holds the FIFO head), valid/err/err_code (per-command status
// pulses), on/amount (per-channel state), increase/decrease/send/receive
// (per-channel action pulses).
module cmd_decoder_mc
  import cmd_dec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AMOUNT_WIDTH = 8,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          received_data,
  input  logic                           stall,
  output logic                           valid,
  output logic                           err,
  output logic [1:0]                     err_code,
  output logic [NUM_CH-1:0]              on,
  output logic [NUM_CH-1:0]              increase,
  output logic [NUM_CH-1:0]              decrease,
  output logic [NUM_CH-1:0]              send,
  output logic [NUM_CH-1:0]              receive,
  output logic [NUM_CH*AMOUNT_WIDTH-1:0] amount
);

  localparam int unsigned AMT_W = AMOUNT_WIDTH;

  // FIFO interface
  logic                  fifo_full, fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0] head;
  logic                  unused_head;

  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign pop         = !fifo_empty && !stall;
  assign unused_head = ^head;

  cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (received_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Decode stage (popped command) and execute-stage registers
  logic                    cmd_vld_q;
  logic [FLAGS_W-1:0]      flags_q;
  logic [AMT_W-1:0]        step_q;
  logic [CH_W-1:0]         ch_q;

  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  err_code_e               err_code_q, err_code_d;
  logic [NUM_CH-1:0]       on_q, on_d;
  logic [NUM_CH-1:0]       inc_q, inc_d, dec_q, dec_d;
  logic [NUM_CH-1:0]       send_q, send_d, recv_q, recv_d;
  logic [NUM_CH*AMT_W-1:0] amount_q, amount_d;

  // Execute-stage working values
  logic             f_on, f_off, f_inc, f_dec, f_rx, f_tx, f_exec;
  logic             in_range;
  logic             cur_on, next_on;
  logic [AMT_W-1:0] cur_amt, base_amt, new_amt;
  logic [AMT_W:0]   sum_w, diff_w;

  assign f_on     = flags_q[BIT_ON];
  assign f_off    = flags_q[BIT_OFF];
  assign f_inc    = flags_q[BIT_INC];
  assign f_dec    = flags_q[BIT_DEC];
  assign f_rx     = flags_q[BIT_RX];
  assign f_tx     = flags_q[BIT_TX];
  assign f_exec   = flags_q[BIT_EXEC];
  assign in_range = (32'(ch_q) < NUM_CH);

  // Check and execute the command held in the decode stage
  always_comb begin
    on_d       = on_q;
    amount_d   = amount_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    inc_d      = '0;
    dec_d      = '0;
    send_d     = '0;
    recv_d     = '0;
    cur_on     = 1'b0;
    cur_amt    = '0;

    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (CH_W'(k) == ch_q) begin
        cur_on  = on_q[k];
        cur_amt = amount_q[k*AMT_W +: AMT_W];
      end
    end

    // State as seen after this command's ON/OFF is applied
    next_on  = f_on ? 1'b1 : (f_off ? 1'b0 : cur_on);
    base_amt = f_off ? '0 : cur_amt;
    // One extra bit exposes overflow/underflow for saturation
    sum_w    = {1'b0, base_amt} + {1'b0, step_q};
    diff_w   = {1'b0, base_amt} - {1'b0, step_q};
    new_amt  = base_amt;
    if (f_exec && f_inc)      new_amt = sum_w[AMT_W]  ? '1 : sum_w[AMT_W-1:0];
    else if (f_exec && f_dec) new_amt = diff_w[AMT_W] ? '0 : diff_w[AMT_W-1:0];

    if (cmd_vld_q) begin
      if ((f_on && f_off) || (f_inc && f_dec)) begin
        err_d      = 1'b1;
        err_code_d = ERR_CONFLICT;
      end else if (!in_range) begin
        err_d      = 1'b1;
        err_code_d = ERR_RANGE;
      end else if ((f_inc || f_dec) && f_exec && !next_on) begin
        err_d      = 1'b1;
        err_code_d = ERR_OFF;
      end else begin
        valid_d = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (CH_W'(k) == ch_q) begin
            on_d[k]                      = next_on;
            amount_d[k*AMT_W +: AMT_W]   = new_amt;
            inc_d[k]                     = f_exec && f_inc;
            dec_d[k]                     = f_exec && f_dec;
            send_d[k]                    = f_exec && f_tx;
            recv_d[k]                    = f_exec && f_rx;
          end
        end
      end
    end
  end

  // Decode-stage capture and registered execute outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld_q  <= 1'b0;
      flags_q    <= '0;
      step_q     <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      on_q       <= '0;
      amount_q   <= '0;
      inc_q      <= '0;
      dec_q      <= '0;
      send_q     <= '0;
      recv_q     <= '0;
    end else begin
      cmd_vld_q <= pop;
      if (pop) begin
        flags_q <= head[FLAGS_W-1:0];
        step_q  <= head[STEP_LSB +: AMT_W];
        ch_q    <= head[CH_LSB +: CH_W];
      end
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      on_q       <= on_d;
      amount_q   <= amount_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      send_q     <= send_d;
      recv_q     <= recv_d;
    end
  end

  assign valid    = valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign on       = on_q;
  assign amount   = amount_q;
  assign increase = inc_q;
  assign decrease = dec_q;
  assign send     = send_q;
  assign receive  = recv_q;

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Bench for cmd_decoder_mc: directed scenarios plus a randomized stream,
// compared against a behavioural per-channel model.
module tb_cmd_decoder_mc;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned FD  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     received_data;
  logic              stall;
  logic              valid, err;
  logic [1:0]        err_code;
  logic [NCH-1:0]    on, increase, decrease, send, receive;
  logic [NCH*AW-1:0] amount;

  always #5 clk = ~clk;

  cmd_decoder_mc #(
    .DATA_WIDTH   (DW),
    .AMOUNT_WIDTH (AW),
    .NUM_CH       (NCH),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .received_data (received_data),
    .stall         (stall),
    .valid         (valid),
    .err           (err),
    .err_code      (err_code),
    .on            (on),
    .increase      (increase),
    .decrease      (decrease),
    .send          (send),
    .receive       (receive),
    .amount        (amount)
  );

  typedef struct packed {
    logic              vld;
    logic              er;
    logic [1:0]        code;
    logic [NCH-1:0]    on;
    logic [NCH-1:0]    inc;
    logic [NCH-1:0]    dec;
    logic [NCH-1:0]    snd;
    logic [NCH-1:0]    rcv;
    logic [NCH*AW-1:0] amt;
  } res_t;

  int tests = 0;
  int fails = 0;

  // Reference state: channel on flags and amounts as plain integers
  int on_m  [NCH];
  int amt_m [NCH];

  logic [DW-1:0]     pending [$];
  res_t              expq    [$];
  logic [NCH-1:0]    last_on;
  logic [NCH*AW-1:0] last_amt;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, x);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < int'(NCH); k++) begin
      on_m[k]  = 0;
      amt_m[k] = 0;
    end
  endfunction

  // Applies one command to the reference state and returns the expected outputs
  function automatic res_t model(input logic [DW-1:0] w);
    res_t r;
    int   ch, step, code, will_on, maxv;
    bit   b_on, b_off, b_inc, b_dec, b_rx, b_tx, b_ex;
    r     = '0;
    b_on  = w[0]; b_off = w[1]; b_inc = w[2]; b_dec = w[3];
    b_rx  = w[4]; b_tx  = w[5]; b_ex  = w[6];
    step  = int'(w[15:8]);
    ch    = int'(w[23:16]);
    maxv  = (1 << AW) - 1;
    code  = 0;
    if ((b_on && b_off) || (b_inc && b_dec)) code = 1;
    else if (ch >= int'(NCH)) code = 2;
    else begin
      will_on = b_on ? 1 : (b_off ? 0 : on_m[ch]);
      if ((b_inc || b_dec) && b_ex && will_on == 0) code = 3;
    end
    if (code != 0) begin
      r.er   = 1'b1;
      r.code = 2'(code);
    end else begin
      r.vld = 1'b1;
      if (b_on) on_m[ch] = 1;
      if (b_off) begin
        on_m[ch]  = 0;
        amt_m[ch] = 0;
      end
      if (b_inc && b_ex) begin
        amt_m[ch] = amt_m[ch] + step;
        if (amt_m[ch] > maxv) amt_m[ch] = maxv;
        r.inc[ch] = 1'b1;
      end
      if (b_dec && b_ex) begin
        amt_m[ch] = amt_m[ch] - step;
        if (amt_m[ch] < 0) amt_m[ch] = 0;
        r.dec[ch] = 1'b1;
      end
      if (b_tx && b_ex) r.snd[ch] = 1'b1;
      if (b_rx && b_ex) r.rcv[ch] = 1'b1;
    end
    for (int k = 0; k < int'(NCH); k++) begin
      r.on[k]          = (on_m[k] != 0);
      r.amt[k*AW +: AW] = AW'(amt_m[k]);
    end
    return r;
  endfunction

  // Called at a negedge: any status pulse must match the next expected result
  task automatic check_outputs();
    res_t obs, e;
    obs = '{valid, err, err_code, on, increase, decrease, send, receive, amount};
    if (valid || err) begin
      tests++;
      assert (expq.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_result obs=%0h exp=none", obs);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("result", 128'(obs), 128'(e));
        last_on  = e.on;
        last_amt = e.amt;
      end
    end else begin
      e     = '0;
      e.on  = last_on;
      e.amt = last_amt;
      chk("idle_hold", 128'(obs), 128'(e));
    end
  endtask

  // Streams pending words with random gaps/stalls until all results are seen
  task automatic run(input int max_cycles, input int stall_pct);
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      check_outputs();
      if (pending.size() == 0 && expq.size() == 0) break;
      stall         = ($urandom_range(0, 99) < stall_pct);
      in_valid      = (pending.size() > 0) && ($urandom_range(0, 3) != 0);
      received_data = (pending.size() > 0) ? pending[0] : DW'($urandom);
      if (in_valid && in_ready) expq.push_back(model(pending.pop_front()));
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    chk("drain_timeout", 128'(pending.size() + expq.size()), 128'(0));
  endtask

  initial begin
    logic [DW-1:0] sw [5];
    logic [AW-1:0] ramp [3];
    res_t          r0;

    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; received_data = '0;
    model_reset();
    last_on = '0; last_amt = '0;

    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_status", 128'({valid, err, err_code}), 128'(0));
    chk("rst_state", 128'({on, amount, increase, decrease, send, receive}), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // ch0 ON: two-cycle latency, single-cycle pulse
    @(negedge clk);
    in_valid = 1'b1; received_data = 32'h0000_0001;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("lat_t0_valid", 128'(valid), 128'(0));
    @(posedge clk); #1;
    chk("lat_t1_valid", 128'(valid), 128'(0));
    @(posedge clk); #1;
    chk("lat_t2", 128'({valid, err, on, amount}), 128'({1'b1, 1'b0, 4'b0001, 32'h0}));
    r0 = model(32'h0000_0001);
    last_on = r0.on; last_amt = r0.amt;
    @(posedge clk); #1;
    chk("lat_t3_valid", 128'(valid), 128'(0));

    // ch1 ON, then three INC|EXEC steps of 0x0A and one of 0xF0 (saturates)
    pending.push_back(32'h0001_0001);
    run(100, 0);
    ramp[0] = 8'h0A; ramp[1] = 8'h14; ramp[2] = 8'h1E;
    for (int i = 0; i < 3; i++) begin
      pending.push_back(32'h0001_0A44);
      run(100, 0);
      chk("ramp_amount", 128'(amount[15:8]), 128'(ramp[i]));
      chk("ramp_pulse", 128'(increase), 128'(4'b0010));
    end
    pending.push_back(32'h0001_F044);
    run(100, 0);
    chk("sat_amount", 128'(amount[15:8]), 128'(8'hFF));

    // Reject codes
    pending.push_back(32'h0000_0003);
    run(100, 0);
    chk("conflict", 128'({err, err_code, valid, on}), 128'({1'b1, 2'd1, 1'b0, 4'b0011}));
    pending.push_back(32'h0007_0001);
    run(100, 0);
    chk("range", 128'({err, err_code}), 128'({1'b1, 2'd2}));
    pending.push_back(32'h0003_0144);
    run(100, 0);
    chk("off_chan", 128'({err, err_code, increase}), 128'({1'b1, 2'd3, 4'b0000}));

    // RX|TX|EXEC on ch2 pulses both together
    pending.push_back(32'h0002_0070);
    run(100, 0);
    chk("txrx", 128'({valid, send, receive}), 128'({1'b1, 4'b0100, 4'b0100}));

    // Stall with five pushes: only four fit, then they drain back-to-back
    sw[0] = 32'h0000_0144; sw[1] = 32'h0001_0248; sw[2] = 32'h0002_0001;
    sw[3] = 32'h0000_0020; sw[4] = 32'h0003_0001;
    @(negedge clk) stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_ready", 128'(in_ready), 128'(i < 4));
      in_valid = 1'b1; received_data = sw[i];
      if (in_ready) expq.push_back(model(sw[i]));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_ready_hold", 128'(in_ready), 128'(0));
    chk("stall_no_exec", 128'({valid, err}), 128'(0));
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("drain_valid", 128'(valid), 128'(j >= 1 && j <= 4));
      check_outputs();
    end
    chk("drain_all", 128'(expq.size()), 128'(0));

    // Reset with three words queued: everything discarded
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; received_data = 32'h0003_0001;
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 128'({valid, err, err_code, on, amount, increase, decrease, send, receive}),
        128'(0));
    chk("midrst_ready", 128'(in_ready), 128'(1));
    model_reset();
    expq.delete();
    last_on = '0; last_amt = '0;
    @(negedge clk) rst_n = 1'b1;
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_outputs();
    end

    // Randomized stream with gaps and stalls
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ch, stp;
      logic [6:0] fl;
      ch  = 8'($urandom_range(0, 5));
      stp = 8'($urandom);
      fl  = 7'($urandom);
      if ($urandom_range(0, 2) != 0) fl[6] = 1'b1;
      if ($urandom_range(0, 3) == 0) fl[0] = 1'b1;
      pending.push_back({8'h00, ch, stp, 1'b0, fl});
    end
    run(8000, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_decoder_mc.md
# cmd_decoder_mc

Multi-channel, buffered successor to the single-channel ultrasonic command decoder. It accepts 32-bit command words from the PS-side AXI register bridge over a valid/ready handshake and queues them in a small FIFO. It decodes one command per cycle, addressed to one of NUM_CH channels, and keeps per-channel on/off state and a saturating amount register. It also emits one-cycle action pulses (increase, decrease, send, receive) toward the per-channel ultrasonic controllers.

## Interface
- DATA_WIDTH, 32, command word width (fixed field map below; must be ≥ 24)
- AMOUNT_WIDTH, 8, width of step field and per-channel amount
- NUM_CH, 4, channel count (1..256)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥ 2)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command word present
- in_ready  out  1  FIFO can accept; equals !full
- received_data  in  DATA_WIDTH  command word
- stall  in  1  downstream hold; no FIFO pop while high
- valid  out  1  pulse: legal command executed
- err  out  1  pulse: command rejected
- err_code  out  2  1 = on/off or inc/dec conflict, 2 = channel out of range, 3 = inc/dec to channel that is off; 0 when err low
- on  out  NUM_CH  per-channel on state (level)
- increase, decrease, send, receive  out  NUM_CH each  per-channel action pulses
- amount  out  NUM_CH*AMOUNT_WIDTH  per-channel amount; channel k at [k*AMOUNT_WIDTH +: AMOUNT_WIDTH]

## Operation
- Field map: bit0 ON, bit1 OFF, bit2 INC, bit3 DEC, bit4 RX, bit5 TX, bit6 EXEC, bits[7+AMOUNT_WIDTH:8] STEP, bits[23:16] CH. Remaining bits are ignored.
- Push when in_valid && in_ready. Pop when the FIFO is non-empty and stall is low; one command per pop.
- Reject checks, in priority order:
  - (ON && OFF) or (INC && DEC) → code 1
  - CH ≥ NUM_CH → code 2
  - (INC || DEC) && EXEC while the target channel's on state after this command's ON/OFF is applied is 0 → code 3
- A rejected command changes no state and produces no pulses. It sets err=1 and valid=0.
- Legal command: sets valid=1 even if no action bits are set (NOP). Effects on channel CH:
  - ON sets on[CH]=1.
  - OFF clears on[CH] and amount[CH] to 0.
  - INC && EXEC: amount[CH] = min(amount+STEP, 2^AMOUNT_WIDTH−1); pulse increase[CH].
  - DEC && EXEC: amount[CH] = max(amount−STEP, 0); pulse decrease[CH].
  - TX && EXEC pulses send[CH]. RX && EXEC pulses receive[CH]. Both may pulse together.
  - INC, DEC, TX and RX without EXEC are no-ops (valid still 1).
- Saturation is computed at AMOUNT_WIDTH+1 bits; no wrap-around.
- Only channel CH changes; all other channels hold.

## Timing
- Reset values: in_ready=1, valid=0, err=0, err_code=0, all pulses 0, on=0, amount=0, FIFO empty.
- A word accepted at edge T, with the FIFO empty and stall low, is popped at edge T+1. Its outputs are registered at edge T+2 (2-cycle latency).
- Sustained throughput is one command per cycle with stall low.
- Pulses, valid and err are exactly one cycle wide per popped command.
- When no pop occurs, pulse and status outputs are 0 and on/amount hold.
- stall high freezes the FIFO head; words already popped still complete.
- Full FIFO: in_ready=0 and in_valid is ignored. A pop and a push in the same cycle on a full FIFO is impossible because in_ready is already low.
- Empty FIFO with a push in the same cycle: no pop that cycle (no bypass).
- in_ready is combinational from the occupancy count only, never from in_valid.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count.
- Reset asserted mid-operation: queued commands are discarded and all outputs return to reset values asynchronously.

## Structure
- Package cmd_dec_pkg holds:
  - bit-position localparams (BIT_ON … BIT_EXEC, STEP_LSB, CH_LSB)
  - err_code enum: ERR_NONE, ERR_CONFLICT, ERR_RANGE, ERR_OFF
- Sub-module cmd_fifo holds the parametrised synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with push/pop/full/empty.
- Top level holds the decode/check logic, the registered execute stage, and the per-channel state arrays.

## Test plan
- Reset then word 0x0000_0001 (ch0 ON) → 2 cycles later valid=1, on=4'b0001, amount all 0.
- Ch1 ON, then 0x0001_0A44 (ch1 INC|EXEC, step 0x0A) three times, then step 0xF0 → amount[1] = 0x0A, 0x14, 0x1E, then 0xFF (saturates); increase[1] pulses each time.
- 0x0000_0003 (ON|OFF) → err=1, code 1, on unchanged; 0x0007_0001 with NUM_CH=4 → err code 2.
- INC|EXEC to an off channel → err code 3, no pulse; 0x0002_0070 (ch2 RX|TX|EXEC) → send[2] and receive[2] in the same cycle, valid=1.
- Hold stall=1 and push 5 words at FIFO_DEPTH=4 → in_ready drops after the 4th, 5th not accepted. Release stall → 4 commands executed on consecutive cycles in order.
- Assert rst_n low with 3 queued words → all outputs zero immediately; after release no queued command executes.
